// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared constants and state encoding for the serial receive deserializer
package serial_rx_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_rx_shreg.sv
// rtl/serial_rx_shreg.sv - 8-bit MSB-first input shift register with comma detect
//
// Ports:
//   clk_32f   in   bit clock
//   reset_L   in   asynchronous reset, active low
//   data_in   in   serial data bit
//   sr_nxt    out  shift register contents including the bit sampled this edge
//   is_comma  out  sr_nxt equals the comma character
module serial_rx_shreg
    import serial_rx_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [BYTE_W-1:0] sr_nxt,
    output logic              is_comma
);

    logic [BYTE_W-1:0] sr;

    assign sr_nxt   = {sr[BYTE_W-2:0], data_in};
    assign is_comma = (sr_nxt == COMMA);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr <= '0;
        end else begin
            sr <= sr_nxt;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - comma-aligned serial-to-byte deserializer
//
// Optional feature: define SERIAL_RX_LOL_EN to enable loss-of-lock detection.
//
// Ports:
//   clk_32f    in   bit clock, one serial bit per rising edge
//   reset_L    in   asynchronous reset, active low
//   data_in    in   serial data, MSB first
//   data_out   out  last received byte, held between boundaries
//   valid_out  out  1 = data byte, 0 = comma/idle or unlocked
//   byte_stb   out  one-cycle pulse when data_out/valid_out update while locked
//   active     out  1 while locked
module serial_paralelo_rx
    import serial_rx_pkg::*;
#(
    parameter int COMMA_LOCK = 4,
    parameter int LOL_THRESH = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_stb,
    output logic              active
);

    localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK);

    logic [BYTE_W-1:0] sr_nxt;
    logic              is_comma;

    rx_state_t         state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [3:0]        bc_cnt, bc_cnt_nxt;
    logic [BYTE_W-1:0] data_nxt;
    logic              valid_nxt, stb_nxt, active_nxt;
    logic              enter_lock;
    logic              boundary;

`ifdef SERIAL_RX_LOL_EN
    localparam logic [7:0] LOL_N = 8'(LOL_THRESH);
    logic [7:0]        lol_cnt, lol_cnt_nxt;
    logic              off_hit, off_hit_nxt;
`endif

    serial_rx_shreg u_shreg (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .sr_nxt   (sr_nxt),
        .is_comma (is_comma)
    );

    // The last bit of a byte is sampled on the edge where bit_cnt==7.
    assign boundary = (bit_cnt == 3'd7);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        bc_cnt_nxt  = bc_cnt;
        data_nxt    = data_out;
        valid_nxt   = valid_out;
        stb_nxt     = 1'b0;
        active_nxt  = active;
        enter_lock  = 1'b0;
`ifdef SERIAL_RX_LOL_EN
        lol_cnt_nxt = lol_cnt;
        off_hit_nxt = off_hit;
`endif

        case (state)
            SEARCH: begin
                // A hit at any phase realigns: the next edge is bit 0 of a new byte.
                if (is_comma) begin
                    bit_cnt_nxt = 3'd0;
                    bc_cnt_nxt  = 4'd1;
                    if (COMMA_LOCK == 1) begin
                        enter_lock = 1'b1;
                    end else begin
                        state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_nxt = bc_cnt + 4'd1;
                        if (bc_cnt + 4'd1 == LOCK_N) begin
                            enter_lock = 1'b1;
                        end
                    end else begin
                        // No realignment here; SEARCH re-examines from the next edge.
                        state_nxt  = SEARCH;
                        bc_cnt_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    data_nxt  = sr_nxt;
                    valid_nxt = !is_comma;
                    stb_nxt   = 1'b1;
`ifdef SERIAL_RX_LOL_EN
                    off_hit_nxt = 1'b0;
                    if (is_comma) begin
                        lol_cnt_nxt = '0;
                    end else if (off_hit) begin
                        lol_cnt_nxt = lol_cnt + 8'd1;
                    end
                    if (lol_cnt_nxt == LOL_N) begin
                        // Lock dropped: data_out keeps the last good byte.
                        state_nxt   = SEARCH;
                        active_nxt  = 1'b0;
                        valid_nxt   = 1'b0;
                        data_nxt    = data_out;
                        stb_nxt     = 1'b0;
                        lol_cnt_nxt = '0;
                        bc_cnt_nxt  = 4'd0;
                    end
                end else if (is_comma) begin
                    off_hit_nxt = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase

        if (enter_lock) begin
            state_nxt  = LOCKED;
            active_nxt = 1'b1;
            data_nxt   = COMMA;
            valid_nxt  = 1'b0;
            stb_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_stb  <= 1'b0;
            active    <= 1'b0;
`ifdef SERIAL_RX_LOL_EN
            lol_cnt   <= '0;
            off_hit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            bc_cnt    <= bc_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            byte_stb  <= stb_nxt;
            active    <= active_nxt;
`ifdef SERIAL_RX_LOL_EN
            lol_cnt   <= lol_cnt_nxt;
            off_hit   <= off_hit_nxt;
`endif
        end
    end

endmodule
